// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the instruction memory.
// Packs four bytes (least-significant byte first) into each 32-bit word and writes
// the words to consecutive word addresses starting at BASE_ADDR. The CPU fetch unit
// is held in reset while a load is in progress and released after the last write.
module imem_loader #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start,
  input  logic [15:0] load_len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  // Widened by one bit so the upper-bound compare against a 16-bit length cannot wrap.
  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);

  state_t      state;
  state_t      state_next;
  logic [15:0] len;        // word count latched on an accepted load_start
  logic [15:0] word_idx;   // index of the word currently being assembled/written
  logic [1:0]  byte_idx;   // next byte lane to fill within the current word
  logic [31:0] word_buf;   // assembly register for the current word
  logic        start_seen; // load_start arrived in a state that accepts it
  logic        byte_fire;  // a byte is transferred this cycle
  logic        len_bad;
  logic        last_word;

  // A zero-length load or one larger than the memory is rejected outright.
  assign len_bad   = (load_len == 16'd0) || ({1'b0, load_len} > DEPTH_LIMIT);
  assign last_word = (word_idx + 16'd1) == len;

  // State register; reset forces IDLE at once, which drops cpu_hold and every strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path can infer a latch.
    state_next = state;
    start_seen = 1'b0;
    byte_fire  = 1'b0;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        done  = (state == S_DONE);
        error = (state == S_ERROR);
        if (load_start) begin
          start_seen = 1'b1;
          state_next = len_bad ? S_ERROR : S_COLLECT;
        end
      end
      S_COLLECT: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        byte_fire  = byte_valid;
        if (byte_valid && (byte_idx == 2'd3)) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        imem_we    = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? S_DONE : S_COLLECT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Length latch, word/byte counters and byte assembly.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
    end else if (start_seen) begin
      len      <= load_len;
      word_idx <= '0;
      byte_idx <= '0;
      word_buf <= '0;
    end else if (byte_fire) begin
      word_buf[{byte_idx, 3'b000} +: 8] <= byte_data;
      byte_idx                          <= byte_idx + 2'd1;  // wraps to lane 0 after lane 3
    end else if (imem_we) begin
      word_idx <= word_idx + 16'd1;
    end
  end

  // Address and data come straight from registers that are frozen during WRITE,
  // so they cannot glitch while the strobe is high; they read zero otherwise.
  assign imem_addr  = imem_we ? (BASE_ADDR + {14'd0, word_idx, 2'b00}) : 32'd0;
  assign imem_wdata = imem_we ? word_buf : 32'd0;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized checks of imem_loader against a
// byte-image reference: word i must land at BASE + 4*i holding bytes 4i..4i+3
// (little-endian), exactly once, for every accepted load.
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic [15:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load_start(load_start),
    .load_len  (load_len),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] prog [4*DEPTH];  // program image the byte stream is drawn from
  wr_t        obs_q [$];       // every write strobe seen on the memory port

  // Record each write strobe mid-cycle.
  always @(negedge clock) begin
    if (!reset && imem_we) obs_q.push_back(wr_t'({imem_addr, imem_wdata}));
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load(input int n);
    load_len   = 16'(n);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_imem_we"},    imem_we,    0);
    check({tag, "_imem_addr"},  imem_addr,  0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_hold"},   cpu_hold,   0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_error"},      error,      0);
  endtask

  // Compare recorded writes with the image: word i at BASE+4i, bytes 4i..4i+3.
  task automatic check_writes(input string tag, input int n);
    check($sformatf("%s_count", tag), obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), obs_q[i].addr, BASE + 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), obs_q[i].data,
            {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]});
    end
    obs_q.delete();
  endtask

  // Stream n words of the image into a load of `total` words.
  // mode 0: back-to-back, 1: valid every other cycle, 2: random bubbles.
  // poke: pulse load_start (len 3) in the middle of the stream; it must be ignored.
  task automatic feed(input int n, input int total, input int mode, input bit poke);
    int   k = 0;
    int   cyc = 0;
    bit   v;
    logic rdy;
    while (k < 4 * n && cyc < 40 * n + 50) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      byte_valid = v;
      byte_data  = v ? prog[k] : 8'($urandom);
      if (poke && k == 10) begin
        load_start = 1'b1;
        load_len   = 16'd3;
      end
      rdy = byte_ready;
      step();
      load_start = 1'b0;
      if (v && rdy) k++;
      cyc++;
    end
    byte_valid = 1'b0;
    check("feed_bytes", k, 4 * n);
    // The fourth byte of the final word must be followed by its write in the next cycle.
    check("last_we",   imem_we,   1);
    check("last_addr", imem_addr, BASE + 32'(4 * (n - 1)));
    check("last_hold", cpu_hold,  1);
    step();
    if (n == total) begin
      check("end_we",   imem_we,  0);
      check("end_done", done,     1);
      check("end_hold", cpu_hold, 0);
      check("end_busy", busy,     0);
    end else begin
      check("mid_busy",  busy,       1);
      check("mid_ready", byte_ready, 1);
      check("mid_done",  done,       0);
    end
  endtask

  initial begin
    int rlen;
    load_start = 1'b0;
    load_len   = 16'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    reset      = 1'b1;
    repeat (3) step();
    check_zero("reset_init");
    reset = 1'b0;
    step();

    // Two-word program, back-to-back bytes.
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h50; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;
    start_load(2);
    check("t2_hold",  cpu_hold,   1);
    check("t2_busy",  busy,       1);
    check("t2_ready", byte_ready, 1);
    feed(2, 2, 0, 1'b0);
    if (obs_q.size() >= 2) begin
      check("t2_word0", obs_q[0].data, 32'h00500013);
      check("t2_word1", obs_q[1].data, 32'h00100093);
    end
    check_writes("t2", 2);

    // Same program with byte_valid toggling.
    start_load(2);
    check("t3_done_cleared", done, 0);
    feed(2, 2, 1, 1'b0);
    check_writes("t3", 2);

    // Rejected lengths: zero and one past capacity.
    start_load(0);
    check("t4a_error",    error,      1);
    check("t4a_done",     done,       0);
    check("t4a_busy",     busy,       0);
    check("t4a_hold",     cpu_hold,   0);
    check("t4a_ready",    byte_ready, 0);
    byte_valid = 1'b1;
    repeat (8) step();
    byte_valid = 1'b0;
    start_load(DEPTH + 1);
    check("t4b_error",    error,      1);
    check("t4b_busy",     busy,       0);
    check("t4b_ready",    byte_ready, 0);
    byte_valid = 1'b1;
    repeat (8) step();
    byte_valid = 1'b0;
    check("t4_no_writes", obs_q.size(), 0);
    obs_q.delete();
    #2 reset = 1'b1;
    #1 check_zero("reset_error");
    step();
    reset = 1'b0;
    step();

    // Full-capacity random program with random bubbles and an ignored restart.
    for (int i = 0; i < 4 * DEPTH; i++) prog[i] = 8'($urandom);
    start_load(DEPTH);
    feed(DEPTH, DEPTH, 2, 1'b1);
    check_writes("t5", DEPTH);
    #2 reset = 1'b1;
    #1 check_zero("reset_done");
    step();
    reset = 1'b0;
    step();

    // Random-length load.
    for (int i = 0; i < 4 * DEPTH; i++) prog[i] = 8'($urandom);
    rlen = $urandom_range(1, 8);
    start_load(rlen);
    feed(rlen, rlen, 2, 1'b0);
    check_writes("trand", rlen);

    // Reset after two bytes of word 1: only word 0 may reach memory.
    start_load(2);
    feed(1, 2, 0, 1'b0);
    byte_valid = 1'b1;
    byte_data  = prog[4];
    step();
    byte_data  = prog[5];
    step();
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("reset_collect");
    repeat (3) step();
    check_writes("t6a", 1);
    reset = 1'b0;
    step();
    for (int i = 0; i < 4 * DEPTH; i++) prog[i] = 8'($urandom);
    start_load(1);
    feed(1, 1, 1, 1'b0);
    check_writes("t6b", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
